window_buffer: RTL and testbench

Circular window of NUM_SEL words of NUM_WIDTH bits each, feeding the NUM_SEL-to-1 `select` mux in the snappy decompressor datapath. Upstream writes 64-bit words in with a valid/ready handshake. The consumer addresses live entries by an offset relative to the oldest entry and retires 1..NUM_SEL entries per cycle. The block drives the flat storage bus and the physical slot index straight into `select`'s `data_in`/`sel`.

---
 rtl/window_buffer_pkg.sv | 29 ++
 rtl/window_buffer.sv | 82 ++++++++
 tb/tb_window_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/window_buffer_pkg.sv
// rtl/window_buffer_pkg.sv - default window geometry and pop classification shared by the window buffer
package window_buffer_pkg;

    localparam int WB_NUM_SEL   = 16;
    localparam int WB_NUM_LOG   = 4;
    localparam int WB_NUM_WIDTH = 64;

    typedef enum logic [1:0] {
        POP_IDLE,
        POP_LEGAL,
        POP_ILLEGAL
    } pop_kind_t;

    // A pop must retire at least one entry and no more than are live this cycle.
    function automatic pop_kind_t classify_pop(
        input logic req,
        input logic too_small,
        input logic too_big
    );
        if (!req) begin
            return POP_IDLE;
        end
        if (too_small || too_big) begin
            return POP_ILLEGAL;
        end
        return POP_LEGAL;
    endfunction

endpackage

// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - circular word window feeding the decompressor select mux
module window_buffer
    import window_buffer_pkg::*;
#(
    parameter int NUM_SEL   = WB_NUM_SEL,
    parameter int NUM_LOG   = WB_NUM_LOG,
    parameter int NUM_WIDTH = WB_NUM_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_valid,
    input  logic [NUM_WIDTH-1:0]         wr_data,
    output logic                         wr_ready,
    output logic [NUM_WIDTH*NUM_SEL-1:0] win_data,
    input  logic [NUM_LOG-1:0]           rd_offset,
    output logic [NUM_LOG-1:0]           win_sel,
    output logic                         rd_avail,
    output logic [NUM_LOG:0]             count,
    input  logic                         pop_en,
    input  logic [NUM_LOG:0]             pop_num,
    output logic                         pop_err
);

    localparam logic [NUM_LOG:0] FULL_COUNT = (NUM_LOG+1)'(NUM_SEL);

    logic [NUM_WIDTH-1:0] mem [NUM_SEL];
    logic [NUM_LOG-1:0]   rd_ptr;
    logic [NUM_LOG-1:0]   wr_ptr;
    logic                 wr_accept;
    pop_kind_t            pop_kind;
    logic [NUM_LOG:0]     pop_amount;
    logic [NUM_LOG:0]     count_next;

    // The write slot is derived from the oldest entry plus occupancy; wrap is free in NUM_LOG bits.
    assign wr_ptr     = rd_ptr + count[NUM_LOG-1:0];
    assign wr_accept  = wr_valid && wr_ready && !clr;
    assign pop_kind   = classify_pop(pop_en && !clr, pop_num == '0, pop_num > count);
    assign pop_amount = (pop_kind == POP_LEGAL) ? pop_num : '0;
    assign count_next = count + {{NUM_LOG{1'b0}}, wr_accept} - pop_amount;

    assign win_sel  = rd_ptr + rd_offset;
    assign rd_avail = {1'b0, rd_offset} < count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
            pop_err  <= 1'b0;
        end else if (clr) begin
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (pop_kind == POP_LEGAL) begin
                rd_ptr <= rd_ptr + pop_num[NUM_LOG-1:0];
            end
            count    <= count_next;
            wr_ready <= (count_next != FULL_COUNT);
            if (pop_kind == POP_ILLEGAL) begin
                pop_err <= 1'b1;
            end
        end
    end

    // Retired slots keep their old contents; only accepted writes touch storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_SEL; g++) begin : g_flat
        assign win_data[NUM_WIDTH*g +: NUM_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_window_buffer.sv
// tb/tb_window_buffer.sv - scoreboard bench for window_buffer against a queue-based window model
module tb_window_buffer;

    localparam int NS = 16;
    localparam int NL = 4;
    localparam int NW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              wr_valid = 1'b0;
    logic [NW-1:0]     wr_data = '0;
    logic              wr_ready;
    logic [NW*NS-1:0]  win_data;
    logic [NL-1:0]     rd_offset = '0;
    logic [NL-1:0]     win_sel;
    logic              rd_avail;
    logic [NL:0]       count;
    logic              pop_en = 1'b0;
    logic [NL:0]       pop_num = '0;
    logic              pop_err;

    window_buffer #(.NUM_SEL(NS), .NUM_LOG(NL), .NUM_WIDTH(NW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .win_data(win_data), .rd_offset(rd_offset), .win_sel(win_sel),
        .rd_avail(rd_avail), .count(count),
        .pop_en(pop_en), .pop_num(pop_num), .pop_err(pop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        bit          rdy;
        bit          err;
        bit          avail;
        int          sel;
        logic [63:0] word;
        bit          chk_word;
        bit          all_zero;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: live entries oldest-first, plus the logical start position in the ring.
    logic [63:0] live_q[$];
    int          base = 0;
    bit          err_m = 0;
    bit          started = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit ready_m();
        return started && (live_q.size() != NS);
    endfunction

    task automatic push_exp(input int off);
        exp_t e;
        e.cnt      = live_q.size();
        e.rdy      = ready_m();
        e.err      = err_m;
        e.avail    = off < live_q.size();
        e.sel      = (base + off) % NS;
        e.chk_word = e.avail;
        e.word     = e.avail ? live_q[off] : 64'h0;
        e.all_zero = 0;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit wv, input logic [63:0] wd, input bit pe, input int pn, input bit cl);
        int cnt;
        bit acc;
        cnt = live_q.size();
        acc = wv && ready_m();
        if (cl) begin
            live_q.delete();
            base = 0;
        end else begin
            if (pe && (pn < 1 || pn > cnt)) begin
                err_m = 1;
            end else if (pe) begin
                repeat (pn) void'(live_q.pop_front());
                base = (base + pn) % NS;
            end
            if (acc) live_q.push_back(wd);
        end
        started = 1;
    endtask

    task automatic cyc(input bit wv, input logic [63:0] wd, input bit pe, input int pn,
                       input bit cl, input int off);
        wr_valid  = wv;
        wr_data   = wd;
        pop_en    = pe;
        pop_num   = pn[NL:0];
        clr       = cl;
        rd_offset = off[NL-1:0];
        push_exp(off);
        @(posedge clk);
        model_step(wv, wd, pe, pn, cl);
        #1;
    endtask

    task automatic reset_mid(input int off);
        exp_t e;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        pop_en    = 1'b0;
        clr       = 1'b0;
        rd_offset = off[NL-1:0];
        live_q.delete();
        base    = 0;
        err_m   = 0;
        started = 0;
        e.cnt = 0; e.rdy = 0; e.err = 0; e.avail = 0; e.sel = off;
        e.word = 64'h0; e.chk_word = 1; e.all_zero = 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    exp_t        mon_e;
    logic [63:0] dut_word;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e    = exp_q.pop_front();
            dut_word = win_data[int'(win_sel)*NW +: NW];
            check("count", 64'(count), 64'(mon_e.cnt));
            check("wr_ready", 64'(wr_ready), 64'(mon_e.rdy));
            check("pop_err", 64'(pop_err), 64'(mon_e.err));
            check("rd_avail", 64'(rd_avail), 64'(mon_e.avail));
            check("win_sel", 64'(win_sel), 64'(mon_e.sel));
            if (mon_e.chk_word) check("sel_data", dut_word, mon_e.word);
            if (mon_e.all_zero) check("win_zero", 64'(win_data == '0), 64'd1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    int pn_r;

    initial begin
        @(posedge clk);
        #1;
        reset_mid(0);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) cyc(1, 64'h11 + 64'(i), 0, 0, 0, 0);
        for (int i = 0; i <= 4; i++) cyc(0, 0, 0, 0, 0, i);

        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 64'h100 + 64'(i), 0, 0, 0, i);
        cyc(1, 64'hdead, 0, 0, 0, 15);
        cyc(0, 0, 0, 0, 0, 15);
        cyc(1, 64'hbeef, 1, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 12);

        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 64'h200 + 64'(i), 0, 0, 0, 0);
        cyc(0, 0, 1, 10, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 64'h300 + 64'(i), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 6);
        cyc(0, 0, 0, 0, 0, 11);

        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 64'h401, 0, 0, 0, 0);
        cyc(1, 64'h402, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 64'h500 + 64'(i), 0, 0, 0, 0);
        cyc(1, 64'h5ff, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            pn_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 17) : $urandom_range(1, 4);
            cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                pn_r, $urandom_range(0, 31) == 0, $urandom_range(0, 15));
        end
        for (int i = 0; i < 6; i++) cyc(1, {$urandom, $urandom}, 0, 0, 0, i);
        reset_mid($urandom_range(0, 15));
        for (int i = 0; i < 60; i++) begin
            pn_r = $urandom_range(0, 5);
            cyc($urandom_range(0, 1) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                pn_r, 0, $urandom_range(0, 15));
        end

        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
